wb_write_port_ctrl: RTL and testbench

- Writer side of the 32x32 register bank. It drives the bank's single write port: RegWrite, write_reg and write_data.
- Merges single-cycle ALU results with variable-latency load results from data memory. Load results are buffered in a small FIFO.
- Keeps a per-register load scoreboard so decode can stall on RAW hazards against outstanding loads.
- Sits between execute/memory stages and Reg_bank, beside the decode stall logic.

---
 rtl/wb_write_port_ctrl.sv | 162 ++++++++++++++++
 tb/tb_wb_write_port_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_write_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_port_ctrl
// Description : Register-bank write-port owner. Merges ALU results with
//               buffered load responses and tracks outstanding loads per
//               register for decode RAW-hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_port_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            issue_valid,
    input  logic            issue_is_load,
    input  logic [4:0]      issue_rd,

    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,

    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,

    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    output logic            hazard,
    output logic [31:0]     busy,

    output logic            RegWrite,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data,
    output logic            ovf_err
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Load-response FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [4:0]      fifo_rd   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             fifo_empty;
    logic             enq;
    logic             deq;
    logic [4:0]       head_rd;
    logic [XLEN-1:0]  head_data;

    // Room is judged from the registered count only, so a same-cycle
    // dequeue never frees a slot for a same-cycle enqueue.
    assign mem_ready  = (count < DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign enq        = mem_valid & mem_ready;
    assign deq        = ~alu_valid & ~fifo_empty;
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (enq) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
        end else if (mem_valid && !mem_ready) begin
            ovf_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Load scoreboard
    // ------------------------------------------------------------------
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_next;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_is_load && (issue_rd != 5'd0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (deq) begin
            clr_mask[head_rd] = 1'b1;
        end
        // Applying the set after the clear lets a freshly issued load win.
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard = busy[chk_rs1] | busy[chk_rs2];

    // ------------------------------------------------------------------
    // Write-port arbitration: ALU first, FIFO head only in ALU bubbles
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (alu_valid) begin
            RegWrite   <= (alu_rd != 5'd0);
            write_reg  <= alu_rd;
            write_data <= alu_data;
        end else if (deq) begin
            RegWrite   <= (head_rd != 5'd0);
            write_reg  <= head_rd;
            write_data <= head_data;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_write_port_ctrl.sv
`default_nettype none
// Directed self-checking bench for wb_write_port_ctrl.
module tb_wb_write_port_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid, issue_is_load;
    logic [4:0]      issue_rd;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic [4:0]      chk_rs1, chk_rs2;
    logic            hazard;
    logic [31:0]     busy;
    logic            RegWrite;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic            ovf_err;

    int checks = 0;
    int passed = 0;

    wb_write_port_ctrl #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_is_load(issue_is_load), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard(hazard), .busy(busy),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_is_load = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
        chk_rs1 = 0; chk_rs2 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #3;
        checks++; if (RegWrite !== 1'b0) $display("FAIL rst_we: got %0h want 0", RegWrite); else passed++;
        checks++; if (write_reg !== 5'd0 || write_data !== 32'd0) $display("FAIL rst_port: got reg=%0d data=%h want 0/0", write_reg, write_data); else passed++;
        checks++; if (busy !== 32'd0) $display("FAIL rst_busy: got %h want 0", busy); else passed++;
        checks++; if (mem_ready !== 1'b1 || ovf_err !== 1'b0 || hazard !== 1'b0) $display("FAIL rst_flags: got ready=%0b ovf=%0b haz=%0b want 1/0/0", mem_ready, ovf_err, hazard); else passed++;
        @(negedge clk);
        rst = 1;
        step();
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        step();
        alu_valid = 0;
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'h1234) $display("FAIL alu_write: got we=%0b reg=%0d data=%h want 1/5/00001234", RegWrite, write_reg, write_data); else passed++;
        step();
        checks++; if (RegWrite !== 1'b0 || write_reg !== 5'd5 || write_data !== 32'h1234) $display("FAIL alu_idle: got we=%0b reg=%0d data=%h want 0/5/00001234", RegWrite, write_reg, write_data); else passed++;
    endtask

    task automatic test_load_hazard();
        issue_valid = 1; issue_is_load = 1; issue_rd = 7;
        step();
        issue_valid = 0; issue_is_load = 0; issue_rd = 0;
        chk_rs1 = 7; chk_rs2 = 2;
        #1;
        checks++; if (busy !== 32'h0000_0080) $display("FAIL ld_busy_set: got %h want 00000080", busy); else passed++;
        checks++; if (hazard !== 1'b1) $display("FAIL ld_hazard: got %0b want 1", hazard); else passed++;
        mem_valid = 1; mem_rd = 7; mem_data = 32'hF0A;
        step();
        mem_valid = 0;
        checks++; if (RegWrite !== 1'b0 || busy !== 32'h0000_0080) $display("FAIL ld_enq: got we=%0b busy=%h want 0/00000080", RegWrite, busy); else passed++;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'hF0A) $display("FAIL ld_write: got we=%0b reg=%0d data=%h want 1/7/00000f0a", RegWrite, write_reg, write_data); else passed++;
        checks++; if (busy !== 32'd0 || hazard !== 1'b0) $display("FAIL ld_clear: got busy=%h haz=%0b want 0/0", busy, hazard); else passed++;
        chk_rs1 = 0; chk_rs2 = 0;
        step();
    endtask

    task automatic test_priority();
        logic [4:0]  exp_reg  [6];
        logic [31:0] exp_data [6];
        exp_reg  = '{5'd10, 5'd11, 5'd12, 5'd3, 5'd4, 5'd4};
        exp_data = '{32'd100, 32'd101, 32'd102, 32'hA, 32'hB, 32'hB};
        alu_valid = 1; alu_rd = 10; alu_data = 100;
        mem_valid = 1; mem_rd = 3; mem_data = 32'hA;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg !== exp_reg[0] || write_data !== exp_data[0]) $display("FAIL pri_w0: got we=%0b reg=%0d data=%h want 1/%0d/%h", RegWrite, write_reg, write_data, exp_reg[0], exp_data[0]); else passed++;
        alu_rd = 11; alu_data = 101; mem_rd = 4; mem_data = 32'hB;
        step();
        mem_valid = 0;
        checks++; if (mem_ready !== 1'b0) $display("FAIL pri_full: got ready=%0b want 0", mem_ready); else passed++;
        checks++; if (RegWrite !== 1'b1 || write_reg !== exp_reg[1] || write_data !== exp_data[1]) $display("FAIL pri_w1: got we=%0b reg=%0d data=%h want 1/%0d/%h", RegWrite, write_reg, write_data, exp_reg[1], exp_data[1]); else passed++;
        alu_rd = 12; alu_data = 102;
        step();
        alu_valid = 0;
        for (int i = 2; i < 5; i++) begin
            checks++; if (RegWrite !== 1'b1 || write_reg !== exp_reg[i] || write_data !== exp_data[i]) $display("FAIL pri_w%0d: got we=%0b reg=%0d data=%h want 1/%0d/%h", i, RegWrite, write_reg, write_data, exp_reg[i], exp_data[i]); else passed++;
            if (i == 3) begin
                checks++; if (mem_ready !== 1'b1) $display("FAIL pri_room: got ready=%0b want 1", mem_ready); else passed++;
            end
            step();
        end
        checks++; if (RegWrite !== 1'b0 || write_reg !== exp_reg[5] || write_data !== exp_data[5]) $display("FAIL pri_drained: got we=%0b reg=%0d data=%h want 0/%0d/%h", RegWrite, write_reg, write_data, exp_reg[5], exp_data[5]); else passed++;
    endtask

    task automatic test_overflow();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        mem_valid = 1; mem_rd = 20; mem_data = 32'h20;
        step();
        mem_rd = 21; mem_data = 32'h21;
        step();
        checks++; if (ovf_err !== 1'b0) $display("FAIL ovf_early: got %0b want 0", ovf_err); else passed++;
        mem_rd = 22; mem_data = 32'h22;
        step();
        mem_valid = 0; alu_valid = 0;
        checks++; if (ovf_err !== 1'b1) $display("FAIL ovf_set: got %0b want 1", ovf_err); else passed++;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd20 || write_data !== 32'h20) $display("FAIL ovf_w20: got we=%0b reg=%0d data=%h want 1/20/00000020", RegWrite, write_reg, write_data); else passed++;
        step();
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd21 || write_data !== 32'h21) $display("FAIL ovf_w21: got we=%0b reg=%0d data=%h want 1/21/00000021", RegWrite, write_reg, write_data); else passed++;
        step();
        checks++; if (RegWrite !== 1'b0 || write_reg !== 5'd21 || ovf_err !== 1'b1) $display("FAIL ovf_drop: got we=%0b reg=%0d ovf=%0b want 0/21/1", RegWrite, write_reg, ovf_err); else passed++;
    endtask

    task automatic test_x0_set_wins();
        issue_valid = 1; issue_is_load = 1; issue_rd = 0;
        step();
        issue_valid = 0; issue_is_load = 0;
        checks++; if (busy !== 32'd0) $display("FAIL x0_busy: got %h want 0", busy); else passed++;
        mem_valid = 1; mem_rd = 0; mem_data = 32'h55;
        step();
        mem_valid = 0;
        step();
        checks++; if (RegWrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'h55) $display("FAIL x0_deq: got we=%0b reg=%0d data=%h want 0/0/00000055", RegWrite, write_reg, write_data); else passed++;
        step();
        checks++; if (RegWrite !== 1'b0 || write_data !== 32'h55) $display("FAIL x0_consumed: got we=%0b data=%h want 0/00000055", RegWrite, write_data); else passed++;
        issue_valid = 1; issue_is_load = 1; issue_rd = 9;
        step();
        issue_valid = 0; issue_is_load = 0;
        mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
        step();
        mem_valid = 0;
        issue_valid = 1; issue_is_load = 1; issue_rd = 9;
        step();
        issue_valid = 0; issue_is_load = 0;
        checks++; if (RegWrite !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h99) $display("FAIL sw_write: got we=%0b reg=%0d data=%h want 1/9/00000099", RegWrite, write_reg, write_data); else passed++;
        checks++; if (busy !== 32'h0000_0200) $display("FAIL sw_busy: got %h want 00000200", busy); else passed++;
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_is_load = 1; issue_rd = 12;
        alu_valid = 1; alu_rd = 13; alu_data = 32'hD;
        mem_valid = 1; mem_rd = 12; mem_data = 32'hC;
        step();
        idle_inputs();
        alu_valid = 1; alu_rd = 14; alu_data = 32'hE;
        #2;
        rst = 0;
        #1;
        checks++; if (RegWrite !== 1'b0 || busy !== 32'd0 || mem_ready !== 1'b1 || ovf_err !== 1'b0) $display("FAIL mid_rst: got we=%0b busy=%h ready=%0b ovf=%0b want 0/0/1/0", RegWrite, busy, mem_ready, ovf_err); else passed++;
        idle_inputs();
        @(negedge clk);
        rst = 1;
        step();
        checks++; if (RegWrite !== 1'b0) $display("FAIL mid_post1: got we=%0b want 0", RegWrite); else passed++;
        step();
        checks++; if (RegWrite !== 1'b0 || write_reg !== 5'd0) $display("FAIL mid_post2: got we=%0b reg=%0d want 0/0", RegWrite, write_reg); else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_hazard();
        test_priority();
        test_overflow();
        test_x0_set_wins();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
